// File: rtl/axi4l_regbank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
// Holds response codes, the write/read FSM state enums and the byte-strobe
// merge used on a write commit.
// Build option: AXI4L_REGBANK_SLVERR_EN selects SLVERR (instead of OKAY)
// as the response to out-of-range accesses.
package axi4l_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI4L_REGBANK_SLVERR_EN
  localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Sized for the widest supported word (64 bits); callers zero-extend and
  // truncate back to DATA_W.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_w;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4l_regbank_wr_fsm.sv
// AXI4-Lite write-side controller: captures AW and W beats independently,
// issues a one-edge commit once both are present, and drives the B channel.
// Ports: clk/rst (sync, active-high), AW/W/B channel signals, and the commit
// strobe with the decoded register index, write data and byte strobes.
// Build option: AXI4L_REGBANK_SLVERR_EN (via the package) sets BRESP for
// out-of-range writes.
//
// state   | meaning
// WR_IDLE | accepting AW and/or W; commit when both are held or arriving
// WR_RESP | BVALID high, both channels stalled until BREADY
module axi4l_regbank_wr_fsm
  import axi4l_regbank_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  localparam int ADDR_LSB = $clog2(DATA_W/8),
  localparam int IDX_W    = ADDR_W - ADDR_LSB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                commit,
  output logic [IDX_W-1:0]    wr_idx,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb
);

  wr_state_t           state_q, state_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                awready_q, awready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;

  logic                aw_hs, w_hs, aw_have, w_have, in_range;
  logic [ADDR_W-1:0]   addr_eff;
  logic                unused_addr_lsb;

  // A beat arriving on the commit edge bypasses its holding register.
  always_comb begin
    aw_hs    = awvalid & awready_q;
    w_hs     = wvalid & wready_q;
    aw_have  = aw_held_q | aw_hs;
    w_have   = w_held_q | w_hs;
    addr_eff = aw_held_q ? awaddr_q : awaddr;
    wr_idx   = addr_eff[ADDR_W-1:ADDR_LSB];
    wr_data  = w_held_q ? wdata_q : wdata;
    wr_strb  = w_held_q ? wstrb_q : wstrb;
    in_range = 32'(wr_idx) < 32'(NUM_REGS);

    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;

    case (state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (aw_have && w_have) begin
          commit    = 1'b1;
          state_d   = WR_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = in_range ? RESP_OKAY : RESP_OOR;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else begin
          awready_d = !aw_have;
          wready_d  = !w_have;
        end
      end
      WR_RESP: begin
        if (bready) begin
          state_d   = WR_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WR_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  assign unused_addr_lsb = ^addr_eff[ADDR_LSB-1:0];

endmodule

// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS registers of DATA_W bits with
// byte-strobe writes, independent read/write channels, per-register reset
// values and a one-cycle write pulse per committed write.
// Ports: S_AXI_* AXI4-Lite slave (sync active-high S_AXI_ARESET),
// reg_q (flat register contents), reg_wr_pulse (per-register write strobe).
// Build option: AXI4L_REGBANK_SLVERR_EN makes out-of-range accesses answer
// SLVERR; otherwise they answer OKAY with zero read data.
module axi4l_regbank
  import axi4l_regbank_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESET,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);

  localparam int ADDR_LSB = $clog2(DATA_W/8);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;

  logic                commit;
  logic [IDX_W-1:0]    wr_idx;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  rd_state_t           rd_state_q, rd_state_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, rd_sel;
  logic [1:0]          rresp_q, rresp_d;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_in_range;
  logic                unused_ok;

  axi4l_regbank_wr_fsm #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_wr_fsm (
    .clk     (S_AXI_ACLK),
    .rst     (S_AXI_ARESET),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .commit  (commit),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  // An out-of-range index matches no register, so it writes nothing and
  // raises no pulse.
  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (32'(wr_idx) == 32'(i))) begin
        regs_d[i]     = DATA_W'(strb_merge(64'(regs_q[i]), 64'(wr_data), 8'(wr_strb)));
        wr_pulse_d[i] = 1'b1;
      end
    end
  end

  // Read data comes from regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rd_idx      = S_AXI_ARADDR[ADDR_W-1:ADDR_LSB];
    rd_in_range = 32'(rd_idx) < 32'(NUM_REGS);
    rd_sel      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx) == 32'(i)) rd_sel = regs_q[i];
    end

    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    case (rd_state_q)
      RD_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rd_state_d = RD_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_sel;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_OOR;
        end else begin
          arready_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) begin
          rd_state_d = RD_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE[i*DATA_W +: DATA_W];
      wr_pulse_q <= '0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wr_pulse_q <= wr_pulse_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign reg_wr_pulse  = wr_pulse_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi4l_regbank.sv
// Self-checking bench for axi4l_regbank (4 x 32-bit registers, non-zero
// reset values). Directed steps plus randomized traffic checked against an
// array model of the register file.
module tb_axi4l_regbank;

  localparam logic [127:0] RV = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
`ifdef AXI4L_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic         clk, areset;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [4];

  axi4l_regbank #(.NUM_REGS(4), .DATA_W(32), .ADDR_W(8), .RESET_VALUE(RV)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < 4; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model[i] = RV[i*32 +: 32];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write transaction; AW and W are offered after their own delays.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int bp, input bit hold_b);
    int   cyc, idx;
    bit   aw_done, w_done, aw_fire, w_fire, inr;
    logic [3:0] exp_p;
    idx   = int'(addr) / 4;
    inr   = idx < 4;
    exp_p = inr ? 4'(1 << idx) : 4'b0;
    if (inr) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    awaddr = addr; wdata = data; wstrb = strb;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      step();
      aw_done = aw_done || aw_fire;
      w_done  = w_done || w_fire;
      cyc++;
      if (!(aw_done && w_done)) begin
        if (aw_done) chk("awready_after_aw", awready, 1'b0);
        if (w_done)  chk("wready_after_w", wready, 1'b0);
        chk("bvalid_before_commit", bvalid, 1'b0);
      end
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake_timeout", aw_done && w_done, 1'b1);
    chk("bvalid_rise", bvalid, 1'b1);
    chk("bresp", bresp, inr ? 2'b00 : OOR_RESP);
    chk("wr_pulse", reg_wr_pulse, exp_p);
    chk("reg_q_after_write", reg_q, model_flat());
    if (!hold_b) begin
      for (int k = 0; k < bp; k++) begin
        step();
        chk("bvalid_hold", bvalid, 1'b1);
        chk("bresp_hold", bresp, inr ? 2'b00 : OOR_RESP);
        chk("awready_in_resp", awready, 1'b0);
        chk("wr_pulse_one_cycle", reg_wr_pulse, 4'b0);
      end
      bready = 1;
      step();
      bready = 0;
      chk("bvalid_drop", bvalid, 1'b0);
      chk("wr_pulse_one_cycle", reg_wr_pulse, 4'b0);
      chk("awready_after_b", awready, 1'b1);
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input int rr_dly);
    int   cyc, idx;
    bit   fire, inr;
    logic [31:0] exp_d;
    idx   = int'(addr) / 4;
    inr   = idx < 4;
    exp_d = inr ? model[idx] : 32'h0;
    araddr = addr; arvalid = 1; cyc = 0; fire = 0;
    while (!fire && cyc < 40) begin
      fire = arready;
      step();
      cyc++;
    end
    arvalid = 0;
    chk("rd_handshake_timeout", fire, 1'b1);
    chk("rvalid_rise", rvalid, 1'b1);
    chk("rdata", rdata, exp_d);
    chk("rresp", rresp, inr ? 2'b00 : OOR_RESP);
    for (int k = 0; k < rr_dly; k++) begin
      step();
      chk("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", rdata, exp_d);
      chk("arready_in_data", arready, 1'b0);
    end
    rready = 1;
    step();
    rready = 0;
    chk("rvalid_drop", rvalid, 1'b0);
    chk("arready_after_r", arready, 1'b1);
  endtask

  initial begin
    logic [31:0] old_v, new_v;
    logic [7:0]  ra;
    areset = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = 0; wstrb = 0;
    model_reset();

    // reset state
    step(); step();
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_reg_q", reg_q, model_flat());
    chk("rst_pulse", reg_wr_pulse, 4'b0);
    areset = 0;
    step();
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_wready", wready, 1'b1);
    chk("post_rst_arready", arready, 1'b1);

    // basic writes with AW and W together, then read back
    do_write(8'h00, 32'h0101FFFF, 4'hF, 0, 0, 0, 0);
    do_write(8'h04, 32'hABCD0001, 4'hF, 0, 0, 0, 0);
    do_write(8'h08, 32'hDEAD0011, 4'hF, 0, 0, 0, 0);
    do_write(8'h0C, 32'hBEEF0011, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(8'(i * 4), 0);

    // byte strobes
    do_write(8'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    do_write(8'h04, 32'h12345678, 4'b0101, 0, 0, 0, 0);
    do_read(8'h04, 0);
    chk("strobe_merge_value", reg_q[63:32], 32'hFF34FF78);

    // channel ordering: W first, then AW first
    do_write(8'h08, 32'h0BAD_F00D, 4'hF, 3, 0, 0, 0);
    do_write(8'h08, 32'hC0FF_EE00, 4'hF, 0, 3, 0, 0);
    do_read(8'h08, 0);

    // backpressure on B and R
    do_write(8'h0C, 32'h5555_AAAA, 4'hF, 0, 0, 5, 0);
    do_read(8'h0C, 5);

    // zero strobe still commits and pulses
    do_write(8'h0C, 32'h1234_5678, 4'h0, 0, 0, 0, 0);

    // out of range
    do_write(8'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0);
    do_read(8'h10, 0);
    do_read(8'hFD, 1);

    // read and write of the same register on the same edge
    old_v = model[1];
    new_v = 32'h7777_8888;
    awaddr = 8'h04; wdata = new_v; wstrb = 4'hF; araddr = 8'h04;
    chk("same_edge_ready", {awready, wready, arready}, 3'b111);
    awvalid = 1; wvalid = 1; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    model[1] = new_v;
    chk("same_edge_rdata_old", rdata, old_v);
    chk("same_edge_reg_new", reg_q, model_flat());
    chk("same_edge_valids", {bvalid, rvalid}, 2'b11);
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    chk("same_edge_done", {bvalid, rvalid}, 2'b00);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
      do_write(ra, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), 0);
      ra = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
      do_read(ra, $urandom_range(0, 2));
    end

    // reset while a write response is pending
    do_write(8'h08, 32'h9999_9999, 4'hF, 0, 0, 0, 1);
    areset = 1;
    step();
    model_reset();
    chk("midrst_bvalid", bvalid, 1'b0);
    chk("midrst_reg_q", reg_q, model_flat());
    chk("midrst_awready", awready, 1'b0);
    areset = 0;
    step();
    chk("midrst_ready_back", {awready, wready, arready}, 3'b111);
    do_write(8'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0);
    do_read(8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4l_regbank.md
# axi4l_regbank

Parametrised AXI4-Lite slave register bank: NUM_REGS software-visible registers of DATA_W bits with byte-strobe writes, independent write/read channels, per-register reset values and per-register write pulses to the fabric. It replaces the fixed four-register example slave inside our IP and sits between the AXI4-Lite interconnect (or the BFM master in the block-design bench) and user logic.

## Interface
- NUM_REGS, 4: number of registers, 1..64.
- DATA_W, 32: data width, 32 or 64.
- ADDR_W, 8: byte-address width; must satisfy 2^ADDR_W ≥ NUM_REGS·DATA_W/8.
- RESET_VALUE, all zeros: NUM_REGS·DATA_W flat vector; register i resets to slice [i·DATA_W +: DATA_W].

Ports:
- S_AXI_ACLK in 1: clock; every transfer is on its rising edge.
- S_AXI_ARESET in 1: synchronous, active-high reset.
- S_AXI_AWADDR in ADDR_W; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in DATA_W; S_AXI_WSTRB in DATA_W/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in ADDR_W; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out DATA_W; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- reg_q out NUM_REGS·DATA_W: current register contents, flat.
- reg_wr_pulse out NUM_REGS: one-cycle pulse per committed write to register i.

## Operation
- Decode: index = addr[ADDR_W-1 : log2(DATA_W/8)]; low byte-offset bits are ignored. Index ≥ NUM_REGS is out of range.
- Write FSM states WR_IDLE, WR_RESP.
  - WR_IDLE: AWREADY = !aw_held, WREADY = !w_held. AW and W are captured independently in either order; each holding register is kept until both are present.
  - Commit edge: the edge on which the second of AW/W completes (or both complete together). On that edge, each byte b with WSTRB[b]=1 is written to the in-range register and the FSM moves to WR_RESP.
  - WR_RESP: BVALID=1, AWREADY=WREADY=0. The FSM returns to WR_IDLE on BVALID&BREADY and clears both held flags.
  - WSTRB=0 commits nothing, returns OKAY and still pulses reg_wr_pulse.
- Read FSM states RD_IDLE, RD_DATA.
  - RD_IDLE: ARREADY=1. On an ARVALID handshake, RDATA is loaded from the register contents as they were before that edge, RRESP is set, and the FSM moves to RD_DATA.
  - RD_DATA: RVALID=1, ARREADY=0; RDATA and RRESP hold until RREADY.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value.
- Out-of-range accesses: writes change no register and produce no pulse. Read data is 0. Response code: see Configuration.

## Timing
- Reset values, applied on the first edge with ARESET=1: AWREADY=WREADY=0 during reset and 1 on the first cycle after it; ARREADY=1 after reset; BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0; reg_q=RESET_VALUE; reg_wr_pulse=0.
- Write latency: BVALID rises the cycle after the commit edge. reg_q updates and reg_wr_pulse[i] is high in that same cycle.
- Read latency: RVALID rises the cycle after the AR handshake.
- Maximum throughput: one write per 2 cycles and one read per 2 cycles when BREADY and RREADY are held high. Reads and writes proceed fully in parallel.
- Reset mid-transaction: held AW/W beats are discarded; BVALID/RVALID drop the next cycle with no response issued; all registers revert.
- VALID inputs are never required to wait for READY. No combinational path runs from any VALID to its READY.

## Configuration
- AXI4L_REGBANK_SLVERR_EN defined: out-of-range writes and reads respond SLVERR (2'b10).
- Undefined: out-of-range accesses respond OKAY (2'b00) and reads return 0.
- In-range accesses respond OKAY in both builds.

## Structure
- Package axi4l_regbank_pkg holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, the wr_state_t and rd_state_t enums, and a strobe-merge function (old, new, strb) → merged word.
- One sub-module, axi4l_regbank_wr_fsm, owns AW/W capture, commit and the B channel. It outputs commit, index, data and strb. The register array and the read path stay in the top level.

## Test plan
- Defaults. Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to addresses 0x0, 0x4, 0x8, 0xC, with AW and W issued together. Read each back → matching data, BRESP=RRESP=OKAY, reg_wr_pulse[i] high for exactly one cycle per write.
- Write 0xFFFFFFFF to 0x4, then write 0x12345678 to 0x4 with WSTRB=4'b0101 → read returns 0xFF34FF78.
- Ordering. W is presented 3 cycles before AW on 0x8 → WREADY drops after the W beat and BVALID rises 1 cycle after the AW handshake. AW-before-W gives the same result.
- Backpressure. Hold BREADY=0 for 5 cycles → BVALID and BRESP stay stable, AWREADY=0 throughout. Hold RREADY=0 → RDATA stays stable.
- Out of range. Write and read 0x10 with NUM_REGS=4 → SLVERR with the macro, OKAY and RDATA=0 without it. reg_q is unchanged in both builds.
- Reset mid-operation. Assert ARESET while BVALID=1 → BVALID=0 next cycle and reg_q=RESET_VALUE. A subsequent write to 0x0 of 0xA5A5A5A5 completes normally.
